// File: rtl/arbitro_ram.sv
// Two-requester round-robin arbiter that sequences single reads/writes into a
// negedge-write, posedge-registered-read RAM and returns read data as a 1-cycle pulse.
module arbitro_ram #(
  parameter int ANCHO       = 8,
  parameter int PROFUNDIDAD = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0]               req_we_i,
  input  logic [2*PROFUNDIDAD-1:0] req_addr_i,
  input  logic [2*ANCHO-1:0]       req_data_i,
  output logic [1:0]               rsp_valid_o,
  output logic [ANCHO-1:0]         rsp_data_o,
  output logic                     ram_we_o,
  output logic [PROFUNDIDAD-1:0]   ram_addr_o,
  output logic [ANCHO-1:0]         ram_data_o,
  input  logic [ANCHO-1:0]         ram_rdata_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} estado_t;

  estado_t                state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   we_q, we_d;
  logic                   last_grant_q, last_grant_d;
  logic                   ram_we_q, ram_we_d;
  logic [PROFUNDIDAD-1:0] ram_addr_q, ram_addr_d;
  logic [ANCHO-1:0]       ram_data_q, ram_data_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [ANCHO-1:0]       rsp_data_q, rsp_data_d;
  logic [1:0]             grant;
  logic                   winner;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = rsp_data_q;
    grant        = 2'b00;
    winner       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          // On a tie the requester that did not win last time goes first.
          winner        = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
          grant[winner] = 1'b1;
          owner_d       = winner;
          we_d          = req_we_i[winner];
          last_grant_d  = winner;
          ram_we_d      = req_we_i[winner];
          ram_addr_d    = winner ? req_addr_i[PROFUNDIDAD +: PROFUNDIDAD]
                                 : req_addr_i[0 +: PROFUNDIDAD];
          ram_data_d    = winner ? req_data_i[ANCHO +: ANCHO]
                                 : req_data_i[0 +: ANCHO];
          state_d       = ISSUE;
        end
      end
      ISSUE: state_d = we_q ? IDLE : WAIT;
      WAIT: begin
        rsp_data_d           = ram_rdata_i;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Ready is combinational, so it is masked while reset holds all outputs low.
  assign req_ready_o = reset_i ? 2'b00 : grant;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_arbitro_ram.sv
// Directed bench for arbitro_ram with a behavioural negedge-write / registered-read RAM.
module tb_arbitro_ram;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [15:0] req_addr_i, req_data_i;
  logic [7:0]  rsp_data_o, ram_addr_o, ram_data_o, ram_rdata_i;
  logic        ram_we_o, busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  always #5 clk_i = ~clk_i;

  arbitro_ram #(.ANCHO(8), .PROFUNDIDAD(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o)
  );

  // RAM model: write commits on the falling edge, read data registered on the rising edge.
  always @(negedge clk_i) if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
  always @(posedge clk_i) ram_rdata_i <= mem[ram_addr_o];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int n, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_we_i[n]           = we;
    req_addr_i[n*8 +: 8]  = a;
    req_data_i[n*8 +: 8]  = d;
  endtask

  task automatic do_write(input int n, input logic [7:0] a, input logic [7:0] d);
    drive(n, 1'b1, a, d);
    req_valid_i = 2'b01 << n;
    #1 chk("wr_ready", req_ready_o, 2'b01 << n);
    step();
    req_valid_i = 2'b00;
    #1;
    chk("wr_ram_we", ram_we_o, 1);
    chk("wr_ram_addr", ram_addr_o, a);
    chk("wr_ram_data", ram_data_o, d);
    chk("wr_busy", busy_o, 1);
    step();
    chk("wr_done_busy", busy_o, 0);
    chk("wr_done_we", ram_we_o, 0);
  endtask

  task automatic do_read(input int n, input logic [7:0] a, input logic [7:0] exp);
    drive(n, 1'b0, a, 8'h00);
    req_valid_i = 2'b01 << n;
    #1 chk("rd_ready", req_ready_o, 2'b01 << n);
    step();
    req_valid_i = 2'b00;
    chk("rd_issue_we", ram_we_o, 0);
    step();
    chk("rd_wait_rsp", rsp_valid_o, 0);
    step();
    chk("rd_rsp_valid", rsp_valid_o, 2'b01 << n);
    chk("rd_rsp_data", rsp_data_o, exp);
    step();
    chk("rd_rsp_clear", rsp_valid_o, 0);
    chk("rd_done_busy", busy_o, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    reset_i     = 1'b1;
    req_valid_i = 2'b00;
    req_we_i    = 2'b00;
    req_addr_i  = 16'h0000;
    req_data_i  = 16'h0000;
    step();
    step();
    reset_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_data", ram_data_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);

    // Single write then read-back by the other requester.
    do_write(0, 8'h05, 8'hA5);
    chk("hold_addr", ram_addr_o, 8'h05);
    do_read(1, 8'h05, 8'hA5);

    // Tie fairness right after reset: grants alternate starting with requester 0.
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    drive(0, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b0, 8'h06, 8'h00);
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("tie_ready", req_ready_o, (i % 2) ? 2'b10 : 2'b01);
      step();
      chk("tie_busy_ready", req_ready_o, 0);
      step();
      step();
      chk("tie_rsp_valid", rsp_valid_o, (i % 2) ? 2'b10 : 2'b01);
      chk("tie_rsp_data", rsp_data_o, (i % 2) ? 8'h00 : 8'hA5);
      step();
    end
    req_valid_i = 2'b00;
    step();

    // Reset asserted while a read from requester 0 sits in WAIT.
    drive(0, 1'b0, 8'h05, 8'h00);
    req_valid_i = 2'b01;
    step();
    req_valid_i = 2'b00;
    step();
    chk("mid_busy_wait", busy_o, 1);
    reset_i = 1'b1;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_ram_addr", ram_addr_o, 0);
    chk("mid_ram_we", ram_we_o, 0);
    chk("mid_rsp_valid", rsp_valid_o, 0);
    step();
    chk("mid_rsp_after", rsp_valid_o, 0);
    chk("mid_rsp_data", rsp_data_o, 0);
    reset_i = 1'b0;

    // Contention: write 0x10<-0x3C by req0 against a read of 0x10 by req1.
    drive(0, 1'b1, 8'h10, 8'h3C);
    drive(1, 1'b0, 8'h10, 8'h00);
    req_valid_i = 2'b11;
    #1 chk("mix_ready0", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b10;
    #1;
    chk("mix_issue_ready", req_ready_o, 0);
    chk("mix_ram_we", ram_we_o, 1);
    step();
    #1 chk("mix_ready1", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b00;
    step();
    chk("mix_wait_rsp", rsp_valid_o, 0);
    step();
    chk("mix_rsp_valid", rsp_valid_o, 2'b10);
    chk("mix_rsp_data", rsp_data_o, 8'h3C);
    step();
    chk("mix_rsp_clear", rsp_valid_o, 0);

    // Address extremes with no aliasing between 0x00 and 0xFF.
    do_write(0, 8'h00, 8'hFF);
    do_write(1, 8'hFF, 8'h01);
    do_read(0, 8'h00, 8'hFF);
    do_read(1, 8'hFF, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_ram.md
Name: arbitro_ram

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port register-file RAM (negedge write, posedge-registered read).
- Accepts one read or write request at a time through valid/ready handshakes, drives the RAM's write-enable, address and data, and returns read data with a one-cycle response pulse.
- Sits between the RAM and its two clients, such as the test sequencer and the display/readout path.

Parameters:
- ANCHO, 8, data word width in bits.
- PROFUNDIDAD, 8, address width in bits (RAM holds 2**PROFUNDIDAD words).

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  2  request valid, bit n = requester n.
- req_ready_o  output  2  request accepted this cycle (one-hot or zero).
- req_we_i  input  2  1 = write, 0 = read, per requester.
- req_addr_i  input  2*PROFUNDIDAD  addresses; requester n uses bits [n*PROFUNDIDAD +: PROFUNDIDAD].
- req_data_i  input  2*ANCHO  write data; requester n uses bits [n*ANCHO +: ANCHO].
- rsp_valid_o  output  2  one-cycle read-response pulse, bit n = requester n.
- rsp_data_o  output  ANCHO  read data, valid while any rsp_valid_o bit is high.
- ram_we_o  output  1  to RAM we_i.
- ram_addr_o  output  PROFUNDIDAD  to RAM addr_i.
- ram_data_o  output  ANCHO  to RAM data_i.
- ram_rdata_i  input  ANCHO  from RAM data_o.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_i=1):
  - State = IDLE.
  - All outputs = 0.
  - Latched request registers = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- Reset asserted mid-transaction: the transaction is dropped; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is set, choose a winner.
    - Single valid requester wins.
    - If both are valid, the requester != last_grant wins.
  - req_ready_o[winner] = 1 combinationally in IDLE only; req_ready_o = 0 in every other state.
  - On the accepting clock edge:
    - Latch owner, we, addr and data.
    - Set last_grant = winner.
    - Go to ISSUE.
  - If no requester is valid, stay in IDLE.
- ISSUE (1 cycle):
  - ram_addr_o = latched addr.
  - ram_data_o = latched data.
  - ram_we_o = latched we.
  - Write: the RAM commits at this cycle's negedge; go to IDLE (no response for writes).
  - Read: go to WAIT.
- WAIT (1 cycle):
  - ram_we_o = 0; ram_addr_o holds the latched address.
  - ram_rdata_i is valid; register it into rsp_data_o at the edge leaving WAIT.
  - Go to RESP.
- RESP (1 cycle):
  - rsp_valid_o[owner] = 1, rsp_data_o = captured word.
  - No backpressure: the requester must take the data this cycle.
  - Go to IDLE.
- Registered RAM outputs:
  - ram_we_o is high only in ISSUE for a write.
  - ram_addr_o and ram_data_o hold their last values outside ISSUE and WAIT.
- Latency, counted from the accept edge:
  - Write: committed one cycle later; next acceptance possible 2 cycles after the previous one.
  - Read: rsp_valid_o is high 3 cycles after accept; throughput is 1 read per 4 cycles.
- Request changes: inputs are sampled only at the accept edge; changes to req_* while not ready are ignored.
- A requester may hold req_valid_i through its own response; it is re-arbitrated in the next IDLE.
- Addresses need no wrap handling; every PROFUNDIDAD-bit value is legal.

Test Plan:
- Reset, then single write: req0 we=1, addr=0x05, data=0xA5 -> req_ready_o=01 for 1 cycle; next cycle ram_we_o=1, ram_addr_o=0x05, ram_data_o=0xA5; busy_o drops after 2 cycles.
- Read-back: req1 read addr=0x05 after the previous write -> 3 cycles after accept, rsp_valid_o=10 for exactly 1 cycle with rsp_data_o=0xA5.
- Tie fairness: both valid continuously, all reads -> grants alternate 0,1,0,1; first grant after reset goes to requester 0; no requester is starved.
- Mixed contention: req0 write 0x10<-0x3C while req1 reads 0x10 in the same cycle -> req0 is granted first; req1's read returns 0x3C.
- Reset mid-read: assert reset_i in WAIT -> all outputs 0 immediately; no rsp_valid_o pulse; after release, the next tie goes to requester 0.
- Address extremes: write then read 0x00 and 0xFF with data 0xFF/0x01 -> each read returns its own word, with no aliasing between the two addresses.
